// File: rtl/tiros_nave.sv
// Projectile manager: spawns shots at the ship nose and moves up to four of them up the screen.
// Latency: one cycle from fire edge / hit / tick to the updated slot outputs and disparou pulse.
// Backpressure: none; a fire edge that cannot be accepted (full, cooldown, pause) is dropped.
//
// Ports:
//   CLOCK_50      system clock
//   reset         asynchronous active-high reset
//   reiniciarJogo synchronous clear to the reset state
//   pausa         freezes motion, firing and the tick counter (hits still honoured)
//   atirar        fire key level; only a rising edge fires
//   x_nave/y_nave ship left x / top y;  largura_nave ship width
//   acerto        1-cycle hit strobe for slot acerto_idx
//   tiro_ativo    per-slot active flags; tiro_x/tiro_y packed 10-bit slot coordinates
//   disparou      1-cycle pulse when a shot is spawned
module tiros_nave #(
    parameter int TICK_DIV = 833333,
    parameter int VEL      = 4,
    parameter int COOLDOWN = 15,
    parameter int TIRO_ALT = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        reiniciarJogo,
    input  logic        pausa,
    input  logic        atirar,
    input  logic [9:0]  x_nave,
    input  logic [9:0]  y_nave,
    input  logic [9:0]  largura_nave,
    input  logic        acerto,
    input  logic [1:0]  acerto_idx,
    output logic [3:0]  tiro_ativo,
    output logic [39:0] tiro_x,
    output logic [39:0] tiro_y,
    output logic        disparou
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [9:0]       VEL_V   = 10'(VEL);
    localparam logic [9:0]       ALT_V   = 10'(TIRO_ALT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             prev_q;
    logic [3:0]       act_q, act_d;
    logic [3:0][9:0]  x_q, x_d;
    logic [3:0][9:0]  y_q, y_d;
    logic             dis_q, dis_d;

    logic       tick;
    logic       fire_edge;
    logic       spawn_ok;
    logic [1:0] spawn_idx;

    always_comb begin
        cnt_d     = cnt_q;
        cd_d      = cd_q;
        act_d     = act_q;
        x_d       = x_q;
        y_d       = y_q;
        dis_d     = 1'b0;
        spawn_idx = 2'd0;

        tick      = (cnt_q == CNT_MAX) && !pausa;
        fire_edge = atirar && !prev_q;

        if (!pausa) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end

        // Lowest free slot, taken from the mask held before this cycle so a slot
        // freed by a hit or retirement right now is not reused in the same cycle.
        for (int i = 3; i >= 0; i--) begin
            if (!act_q[i]) begin
                spawn_idx = 2'(i);
            end
        end
        spawn_ok = fire_edge && !pausa && (cd_q == '0) && !(&act_q);

        // Motion only touches slots that were already active, so a slot spawned
        // on a tick cycle keeps its spawn position.
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (act_q[i]) begin
                    if (y_q[i] >= VEL_V) begin
                        y_d[i] = y_q[i] - VEL_V;
                    end else begin
                        act_d[i] = 1'b0;
                        x_d[i]   = '0;
                        y_d[i]   = '0;
                    end
                end
            end
            if (cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end
        end

        // Hit is applied after motion so it wins on the same slot.
        if (acerto && act_q[acerto_idx]) begin
            act_d[acerto_idx] = 1'b0;
            x_d[acerto_idx]   = '0;
            y_d[acerto_idx]   = '0;
        end

        // A spawn slot was inactive, so neither motion nor a hit touched it above.
        if (spawn_ok) begin
            act_d[spawn_idx] = 1'b1;
            x_d[spawn_idx]   = x_nave + (largura_nave >> 1);
            y_d[spawn_idx]   = (y_nave < ALT_V) ? '0 : y_nave - ALT_V;
            cd_d             = CD_LOAD;
            dis_d            = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            cd_q   <= '0;
            prev_q <= 1'b1;   // a key held through reset must be released first
            act_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            dis_q  <= 1'b0;
        end else if (reiniciarJogo) begin
            cnt_q  <= '0;
            cd_q   <= '0;
            prev_q <= 1'b1;
            act_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            dis_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cd_q   <= cd_d;
            prev_q <= atirar;
            act_q  <= act_d;
            x_q    <= x_d;
            y_q    <= y_d;
            dis_q  <= dis_d;
        end
    end

    assign tiro_ativo = act_q;
    assign tiro_x     = x_q;
    assign tiro_y     = y_q;
    assign disparou   = dis_q;

endmodule

// File: tb/tb_tiros_nave.sv
// Bench for tiros_nave with a small tick divider; directed scenarios plus random stimulus.
// Outputs are sampled 1 time unit after the rising edge and compared to a slot-level model.
// Inputs are driven between edges; there is no backpressure to exercise.
module tb_tiros_nave;

    localparam int TD  = 4;
    localparam int V   = 4;
    localparam int CDN = 2;
    localparam int ALT = 8;

    logic        clk = 1'b0;
    logic        reset, reiniciarJogo, pausa, atirar, acerto;
    logic [9:0]  x_nave, y_nave, largura_nave;
    logic [1:0]  acerto_idx;
    logic [3:0]  tiro_ativo;
    logic [39:0] tiro_x, tiro_y;
    logic        disparou;

    always #5 clk = ~clk;

    tiros_nave #(.TICK_DIV(TD), .VEL(V), .COOLDOWN(CDN), .TIRO_ALT(ALT)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .reiniciarJogo(reiniciarJogo),
        .pausa        (pausa),
        .atirar       (atirar),
        .x_nave       (x_nave),
        .y_nave       (y_nave),
        .largura_nave (largura_nave),
        .acerto       (acerto),
        .acerto_idx   (acerto_idx),
        .tiro_ativo   (tiro_ativo),
        .tiro_x       (tiro_x),
        .tiro_y       (tiro_y),
        .disparou     (disparou)
    );

    // Reference model: slot list with integer coordinates.
    bit m_act[4];
    int m_x[4];
    int m_y[4];
    int m_cd, m_cnt;
    bit m_prev, m_dis, m_tick;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0; m_cnt = 0; m_prev = 1; m_dis = 0; m_tick = 0;
    endfunction

    function automatic void retire(input int s);
        m_act[s] = 0; m_x[s] = 0; m_y[s] = 0;
    endfunction

    function automatic void model_step();
        bit old[4];
        bit fire, spawn;
        int idx;
        m_tick = 0;
        if (reiniciarJogo) begin
            model_reset();
            return;
        end
        old    = m_act;
        m_tick = !pausa && (m_cnt == TD - 1);
        fire   = atirar && !m_prev;
        m_prev = atirar;
        if (!pausa) m_cnt = (m_cnt + 1) % TD;
        idx = -1;
        for (int i = 0; i < 4; i++) if (!old[i] && idx < 0) idx = i;
        spawn = fire && !pausa && (m_cd == 0) && (idx >= 0);
        if (m_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (old[i]) begin
                    if (m_y[i] >= V) m_y[i] -= V;
                    else retire(i);
                end
            end
            if (m_cd > 0) m_cd--;
        end
        if (acerto && old[acerto_idx]) retire(int'(acerto_idx));
        if (spawn) begin
            m_act[idx] = 1;
            m_x[idx]   = (int'(x_nave) + int'(largura_nave) / 2) % 1024;
            m_y[idx]   = (int'(y_nave) < ALT) ? 0 : int'(y_nave) - ALT;
            m_cd       = CDN;
        end
        m_dis = spawn;
    endfunction

    function automatic logic [3:0] exp_act();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_act[i];
        return r;
    endfunction

    function automatic logic [39:0] exp_x();
        logic [39:0] r;
        for (int i = 0; i < 4; i++) r[10*i +: 10] = 10'(m_x[i]);
        return r;
    endfunction

    function automatic logic [39:0] exp_y();
        logic [39:0] r;
        for (int i = 0; i < 4; i++) r[10*i +: 10] = 10'(m_y[i]);
        return r;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("ativo",    tiro_ativo, exp_act());
        chk("x",        tiro_x,     exp_x());
        chk("y",        tiro_y,     exp_y());
        chk("disparou", disparou,   m_dis);
    endtask

    task automatic restart();
        atirar = 0; reiniciarJogo = 1;
        step();
        reiniciarJogo = 0;
        step();
    endtask

    task automatic press();
        atirar = 1;
        step();
        atirar = 0;
    endtask

    // Step until the next cycle is a movement tick, then step through it.
    task automatic to_tick();
        for (int k = 0; k < TD && m_cnt != TD - 1; k++) step();
        step();
    endtask

    logic [39:0] snap_y;
    int          e1;

    initial begin
        reset = 1; reiniciarJogo = 0; pausa = 0; atirar = 1; acerto = 0; acerto_idx = 0;
        x_nave = 350; y_nave = 420; largura_nave = 15;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ativo", tiro_ativo, 0);
        chk("rst_x",     tiro_x,     0);
        chk("rst_y",     tiro_y,     0);
        chk("rst_dis",   disparou,   0);

        // 1: key held across reset release does not fire
        reset = 0;
        repeat (10) begin
            step();
            chk("s1_held_dis",   disparou,   0);
            chk("s1_held_ativo", tiro_ativo, 0);
        end
        atirar = 0;
        step();
        press();
        chk("s1_spawn_ativo", tiro_ativo, 4'b0001);

        // 2: spawn position and first move
        restart();
        press();
        chk("s2_ativo", tiro_ativo,   4'b0001);
        chk("s2_x0",    tiro_x[9:0],  357);
        chk("s2_y0",    tiro_y[9:0],  412);
        chk("s2_dis",   disparou,     1);
        step();
        chk("s2_dis_pulse", disparou, 0);
        to_tick();
        chk("s2_y0_moved", tiro_y[9:0], 408);

        // 3: slots fill in order, fifth press dropped; cooldown drop
        restart();
        for (int p = 0; p < 5; p++) begin
            press();
            chk("s3_fill_dis",   disparou,   (p < 4) ? 1 : 0);
            chk("s3_fill_ativo", tiro_ativo, (p < 4) ? (1 << (p + 1)) - 1 : 15);
            repeat (3 * TD) step();
        end
        restart();
        press();
        chk("s3_first_dis", disparou, 1);
        repeat (3) step();
        press();
        chk("s3_cooldown_drop", disparou,   0);
        chk("s3_cooldown_act",  tiro_ativo, 4'b0001);

        // 4: spawn near the top and retire
        restart();
        y_nave = 14;
        press();
        chk("s4_y0_spawn", tiro_y[9:0], 6);
        to_tick();
        chk("s4_y0_tick1", tiro_y[9:0], 2);
        to_tick();
        chk("s4_retired", tiro_ativo[0], 0);
        chk("s4_y0_zero", tiro_y[9:0],   0);

        // 5: hit + tick + fire edge in one cycle
        restart();
        y_nave = 420;
        press();
        repeat (3 * TD) step();
        press();
        repeat (3 * TD) step();
        for (int k = 0; k < TD && m_cnt != TD - 1; k++) step();
        e1 = m_y[1] - V;
        atirar = 1; acerto = 1; acerto_idx = 0;
        step();
        atirar = 0; acerto = 0;
        chk("s5_ativo", tiro_ativo,    4'b0110);
        chk("s5_x0",    tiro_x[9:0],   0);
        chk("s5_y0",    tiro_y[9:0],   0);
        chk("s5_y1",    tiro_y[19:10], e1);
        chk("s5_y2",    tiro_y[29:20], 412);
        chk("s5_dis",   disparou,      1);

        // 6: pause freezes everything; press during pause is lost
        snap_y = exp_y();
        pausa = 1;
        for (int k = 0; k < 20; k++) begin
            atirar = (k >= 5);
            step();
            chk("s6_frozen_y", tiro_y,   snap_y);
            chk("s6_no_fire",  disparou, 0);
        end
        pausa = 0;
        repeat (8) begin
            step();
            chk("s6_resume_no_fire", disparou, 0);
        end
        atirar = 0; reiniciarJogo = 1;
        step();
        reiniciarJogo = 0;
        chk("s6_clr_ativo", tiro_ativo, 0);
        chk("s6_clr_x",     tiro_x,     0);
        chk("s6_clr_y",     tiro_y,     0);
        chk("s6_clr_dis",   disparou,   0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reiniciarJogo = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) pausa = ~pausa;
            atirar       = ($urandom_range(0, 2) == 0);
            acerto       = ($urandom_range(0, 5) == 0);
            acerto_idx   = 2'($urandom_range(0, 3));
            x_nave       = 10'($urandom_range(0, 1023));
            largura_nave = 10'($urandom_range(0, 1023));
            y_nave       = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15))
                                                       : 10'($urandom_range(0, 1023));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
